// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer
//   Transmit end of the Hamming(7,4) link. Accepts a 4-bit data word over a
//   valid/ready handshake, encodes it into a 7-bit codeword, optionally flips
//   one codeword bit for error-correction lab work, and shifts the frame out
//   on a serial line: start bit (0), codeword bits 6..0 MSB first, stop bit (1).
//   Every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   data_in      data word i3..i0
//   valid_in     data_in is valid
//   err_en       enable single-bit error injection (sampled at accept)
//   err_pos      Hamming position 1..7 to invert, 0 = none (sampled at accept)
//   ready_out    high only while idle; accept = valid_in && ready_out
//   tx_serial    registered serial line, idles high
//   busy         high whenever a frame is in progress
//   done         one-cycle pulse after the stop bit completes
//   codeword_out codeword latched at accept, after injection
//                [6:0] = i3,i2,i1,c2,i0,c1,c0 (Hamming positions 7..1)
//   err_injected latched at accept: a bit was inverted
module hamming_tx_serializer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       valid_in,
   input  logic       err_en,
   input  logic [2:0] err_pos,
   output logic       ready_out,
   output logic       tx_serial,
   output logic       busy,
   output logic       done,
   output logic [6:0] codeword_out,
   output logic       err_injected
);

   // A 1-bit counter is kept for CLKS_PER_BIT = 1 so the width is never zero.
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [6:0]       shift_q, shift_d;
   logic [6:0]       cw_q, cw_d;
   logic             inj_q, inj_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;

   logic             period_end;
   logic [6:0]       inj_mask;
   logic [6:0]       cw_accept;

   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3], d[2], d[1], d[3] ^ d[2] ^ d[1],
              d[0], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
   endfunction

   // Position p lives at codeword bit p-1; position 0 means no injection.
   function automatic logic [6:0] err_mask(input logic en, input logic [2:0] pos);
      logic [6:0] m;
      m = '0;
      if (en && (pos != 3'd0)) begin
         m = 7'd1 << (pos - 3'd1);
      end
      return m;
   endfunction

   assign period_end = (cnt_q == CNT_LAST);
   assign inj_mask   = err_mask(err_en, err_pos);
   assign cw_accept  = encode(data_in) ^ inj_mask;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      cw_d      = cw_q;
      inj_d     = inj_q;
      tx_d      = tx_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (valid_in) begin
               state_d = START;
               tx_d    = 1'b0;
               cw_d    = cw_accept;
               shift_d = cw_accept;
               inj_d   = |inj_mask;
               cnt_d   = '0;
            end
         end
         START: begin
            if (period_end) begin
               state_d   = DATA;
               tx_d      = shift_q[6];
               shift_d   = {shift_q[5:0], 1'b0};
               bit_idx_d = 3'd6;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (period_end) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd0) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q - 3'd1;
                  tx_d      = shift_q[6];
                  shift_d   = {shift_q[5:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (period_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         cw_q      <= '0;
         inj_q     <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         cw_q      <= cw_d;
         inj_q     <= inj_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

   assign ready_out    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign tx_serial    = tx_q;
   assign done         = done_q;
   assign codeword_out = cw_q;
   assign err_injected = inj_q;

endmodule
